sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO: next generation of the fixed 8-deep, 8-bit FIFO memory.
- Owns its own pointers, occupancy count and status flags internally.
- Adds registered read data with a valid strobe, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and synchronous flush.
- Used as the buffering stage between the register-file/ALU side and the serial-interface side whenever both run on W_CLK.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries.
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- W_CLK  in  1  clock; all state updates on rising edge.
- W_RST  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of pointers, count and rd_valid.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  registered read word.
- rd_valid  out  1  rd_data holds a newly popped word this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (W_RST=0, async): wptr=rptr=0, count=0, rd_data=0, rd_valid=0, overflow=underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=0. Memory array is not reset; its contents are don't-care until written.
- Flags are combinational decodes of the count register, so they update the cycle after the count changes.
- Write accepted iff wr_en && !full: mem[wptr] <= wr_data; wptr increments mod DEPTH (natural wrap).
- Read accepted iff rd_en && !empty: rd_data <= mem[rptr], rd_valid <= 1 on the same edge; rptr increments mod DEPTH. Latency is one cycle from rd_en to rd_data/rd_valid.
- No accepted read: rd_valid <= 0 and rd_data holds its last value.
- Acceptance is judged on the registered full/empty of the current cycle:
  - When full, a write is rejected even if a read is accepted in the same cycle.
  - When empty, a read is rejected even if a write is accepted in the same cycle (no fall-through).
- Count update: +1 on accepted write only; -1 on accepted read only; unchanged when both or neither are accepted.
- Simultaneous accepted read and write at the same address cannot occur, because that requires empty or full.
- Error flags:
  - overflow <= 1 on wr_en && full.
  - underflow <= 1 on rd_en && empty.
  - Both hold until clr_err. If clr_err coincides with a new error event, the set wins.
- flush has priority over wr_en and rd_en in the same cycle:
  - wptr=rptr=0, count=0, rd_valid=0.
  - rd_data, the error flags and memory are untouched.
  - Any request in that cycle is ignored and does not set error flags.
- Reset asserted mid-operation: pointers, count, flags and outputs return to reset values immediately; in-flight data is lost.
- Out-of-range AF_LEVEL/AE_LEVEL is an elaboration-time error (initial check with $error).

Decomposition:
- Shared constants file: default FIFO DATA_WIDTH/ADDR_WIDTH used across the system, plus derived DEPTH.
- One sub-module, fifo_ram_sp:
  - DATA_WIDTH x DEPTH array.
  - Synchronous write with enable, synchronous registered read with enable.
  - No reset on the array.
- Top level holds pointers, count, flag decode and error logic.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=1):
1. Reset then idle -> empty=1, almost_empty=1, full=0, count=0, rd_valid=0, rd_data=0x00.
2. Write 0x11..0x88 on 8 consecutive cycles -> count steps 1..8; almost_empty drops when count=2; almost_full rises when count=6; full=1 at count=8. Then a 9th write of 0x99 -> rejected, overflow=1, count stays 8.
3. From full, assert rd_en 8 cycles -> rd_data 0x11..0x88 each one cycle after its rd_en with rd_valid=1; empty=1 afterwards. Then an extra rd_en -> underflow=1, rd_valid=0.
4. Wrap-around: fill 5 words, read 5, write 0xA0..0xA7 (8 words), read 8 -> order preserved across pointer wrap, count returns to 0.
5. Count=3: wr_en=1 and rd_en=1 together for 4 cycles -> count stays 3, data streams in order. At full: both asserted -> only the read accepted, count 8->7, overflow=1.
6. Count=4 with overflow=1: flush with wr_en=1 -> count=0, empty=1, rd_valid=0, overflow still 1. Then clr_err -> overflow=0. Then W_RST pulse mid-write burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/sync_fifo_param_pkg.sv
// Shared FIFO sizing defaults and the status-flag bundle used by sync_fifo_param.
package sync_fifo_param_pkg;
  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;
endpackage

// File: rtl/sync_fifo_param_ram.sv
// Single-port-style FIFO storage: synchronous write, registered enabled read.
module fifo_ram_sp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge W_CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; the array itself powers up as don't-care.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read, level flags, sticky errors and flush.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_AF   = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] CNT_AE   = (ADDR_WIDTH+1)'(AE_LEVEL);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH-1) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH-1);
  end

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic                  wr_acc, rd_acc;
  fifo_flags_t           flg;

  // Flags decode the registered count, so acceptance uses this cycle's state.
  assign flg.full         = (count == CNT_FULL);
  assign flg.empty        = (count == '0);
  assign flg.almost_full  = (count >= CNT_AF);
  assign flg.almost_empty = (count <= CNT_AE);

  assign full         = flg.full;
  assign empty        = flg.empty;
  assign almost_full  = flg.almost_full;
  assign almost_empty = flg.almost_empty;

  assign wr_acc = !flush && wr_en && !flg.full;
  assign rd_acc = !flush && rd_en && !flg.empty;

  fifo_ram_sp #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .W_CLK (W_CLK),
    .W_RST (W_RST),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rptr),
    .rdata (rd_data)
  );

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rd_valid <= rd_acc;
    end
  end

  // A new error event outranks clr_err in the same cycle; flushed requests never flag.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (!flush && wr_en && flg.full)  || (overflow  && !clr_err);
      underflow <= (!flush && rd_en && flg.empty) || (underflow && !clr_err);
    end
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed-vector bench for sync_fifo_param at the default 8x8, AF=6, AE=1 configuration.
module tb_sync_fifo_param;
  logic       W_CLK = 1'b0;
  logic       W_RST = 1'b1;
  logic       flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
    .W_CLK(W_CLK), .W_RST(W_RST), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 W_CLK = ~W_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge W_CLK);
    #1;
  endtask

  task automatic chk_lvl(input string tag, input int c, input logic f, input logic e,
                         input logic af, input logic ae);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".af"}, 32'(almost_full), 32'(af));
    chk({tag, ".ae"}, 32'(almost_empty), 32'(ae));
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; rd_en = 1'b0; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] d);
    rd_en = 1'b1; wr_en = 1'b0;
    step();
    rd_en = 1'b0;
    chk({tag, ".data"}, 32'(rd_data), 32'(d));
    chk({tag, ".vld"}, 32'(rd_valid), 32'd1);
  endtask

  initial begin
    logic [7:0] exp_q [$];

    // 1. reset then idle
    #1 W_RST = 1'b0;
    #2;
    chk_lvl("rst", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst.rd_valid", 32'(rd_valid), 32'd0);
    chk("rst.rd_data", 32'(rd_data), 32'h00);
    chk("rst.ovf", 32'(overflow), 32'd0);
    chk("rst.unf", 32'(underflow), 32'd0);
    step();
    W_RST = 1'b1;
    step(); step();
    chk_lvl("idle", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("idle.rd_valid", 32'(rd_valid), 32'd0);

    // 2. fill 0x11..0x88, watching level flags per word
    for (int k = 1; k <= 8; k++) begin
      push(8'(k * 8'h11));
      chk_lvl($sformatf("fill%0d", k), k, k == 8, 1'b0, k >= 6, k <= 1);
    end
    push(8'h99);
    chk("ovf.count", 32'(count), 32'd8);
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.full", 32'(full), 32'd1);

    // 3. drain in order, then one extra read
    for (int k = 1; k <= 8; k++) pop_chk($sformatf("drain%0d", k), 8'(k * 8'h11));
    chk_lvl("drained", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("unf.flag", 32'(underflow), 32'd1);
    chk("unf.vld", 32'(rd_valid), 32'd0);
    chk("unf.hold", 32'(rd_data), 32'h88);
    step();
    chk("idle.vld", 32'(rd_valid), 32'd0);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("clr.ovf", 32'(overflow), 32'd0);
    chk("clr.unf", 32'(underflow), 32'd0);

    // 4. wrap-around
    for (int k = 1; k <= 5; k++) push(8'(k));
    for (int k = 1; k <= 5; k++) pop_chk($sformatf("wrapA%0d", k), 8'(k));
    for (int k = 0; k < 8; k++) push(8'hA0 + 8'(k));
    chk("wrap.full", 32'(full), 32'd1);
    for (int k = 0; k < 8; k++) pop_chk($sformatf("wrapB%0d", k), 8'hA0 + 8'(k));
    chk_lvl("wrap.end", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("wrap.ovf", 32'(overflow), 32'd0);

    // 5. simultaneous read+write at count 3, then at full
    for (int k = 0; k < 3; k++) begin
      push(8'hB0 + 8'(k));
      exp_q.push_back(8'hB0 + 8'(k));
    end
    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hC0 + 8'(k);
      exp_q.push_back(wr_data);
      step();
      chk($sformatf("rw%0d.data", k), 32'(rd_data), 32'(exp_q.pop_front()));
      chk($sformatf("rw%0d.count", k), 32'(count), 32'd3);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push(8'hD0 + 8'(k));
      exp_q.push_back(8'hD0 + 8'(k));
    end
    chk("rwfull.full", 32'(full), 32'd1);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rwfull.data", 32'(rd_data), 32'(exp_q.pop_front()));
    chk("rwfull.count", 32'(count), 32'd7);
    chk("rwfull.ovf", 32'(overflow), 32'd1);

    // 6. flush, clr_err, async reset mid-burst
    for (int k = 0; k < 3; k++) pop_chk($sformatf("pre%0d", k), exp_q.pop_front());
    chk("preflush.count", 32'(count), 32'd4);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
    step();
    flush = 1'b0; wr_en = 1'b0;
    chk_lvl("flush", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("flush.vld", 32'(rd_valid), 32'd0);
    chk("flush.data", 32'(rd_data), 32'hD0);
    chk("flush.ovf", 32'(overflow), 32'd1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("clr2.ovf", 32'(overflow), 32'd0);
    push(8'h77);
    pop_chk("postflush", 8'h77);
    wr_en = 1'b1; wr_data = 8'h31; step();
    wr_data = 8'h32; step();
    chk("burst.count", 32'(count), 32'd2);
    #3 W_RST = 1'b0;
    #1;
    chk_lvl("midrst", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("midrst.data", 32'(rd_data), 32'h00);
    chk("midrst.vld", 32'(rd_valid), 32'd0);
    wr_en = 1'b0;
    step();
    W_RST = 1'b1;
    step();
    chk("afterrst.count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
